// File: rtl/au_sequencer_if.sv
// Sequencer <-> arithmetic unit link: operand/control launch plus result/done return.
// Valid/ready: au_start is a one-cycle launch strobe with operands valid alongside it; au_done qualifies au_result for one cycle.
interface au_sequencer_if #(
    parameter int W = 24
);
    logic         au_start;
    logic [W-1:0] au_R;
    logic [W-1:0] au_S;
    logic [W-1:0] au_Iimm;
    logic [1:0]   au_op_sel;
    logic [1:0]   au_mul_y_sel;
    logic [W-1:0] au_result;
    logic         au_done;
    logic         au_busy;

    modport master (
        output au_start, au_R, au_S, au_Iimm, au_op_sel, au_mul_y_sel,
        input  au_result, au_done, au_busy
    );

    modport slave (
        input  au_start, au_R, au_S, au_Iimm, au_op_sel, au_mul_y_sel,
        output au_result, au_done, au_busy
    );
endinterface

// File: rtl/au_sequencer.sv
// Micro-sequencer: steps a 16-entry program through an external arithmetic unit,
// keeping an 8-entry register file and a watchdog on each outstanding operation.
module au_sequencer #(
    parameter int W    = 24,
    parameter int FRAC = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [3:0]    prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          reg_we,
    input  logic [2:0]    reg_addr,
    input  logic [W-1:0]  reg_wdata,
    input  logic [2:0]    rd_addr,
    output logic [W-1:0]  rd_data,
    input  logic          run,
    output logic          busy,
    output logic          seq_done,
    output logic          err,
    output logic [1:0]    state_dbg,
    au_sequencer_if.master au
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [W-2:0] IMM_ONE = {{(W-2){1'b0}}, 1'b1} << FRAC;

    state_t       state;
    logic [3:0]   pc;
    logic [5:0]   wd;
    logic [15:0]  imem [16];
    logic [W-1:0] regs [8];

    logic [15:0]  instr;
    logic [1:0]   i_op;
    logic [1:0]   i_ysel;
    logic [2:0]   i_rd;
    logic [2:0]   i_ra;
    logic [2:0]   i_rb;
    logic         i_sgn;
    logic         i_last;
    logic         unused_bits;

    assign instr       = imem[pc];
    assign i_op        = instr[15:14];
    assign i_ysel      = instr[13:12];
    assign i_rd        = instr[11:9];
    assign i_ra        = instr[8:6];
    assign i_rb        = instr[5:3];
    assign i_sgn       = instr[2];
    assign i_last      = instr[1];
    assign unused_bits = ^{instr[0], au.au_busy};

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Single register-file write port: host writes only while idle, writeback only in WAIT.
    logic         wb_en;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] wr_data;

    assign wb_en = (state == S_WAIT) && au.au_done;

    always_comb begin
        wr_en   = wb_en || (reg_we && state == S_IDLE);
        wr_addr = reg_addr;
        wr_data = reg_wdata;
        if (wb_en) begin
            wr_addr = i_rd;
            wr_data = au.au_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            for (int i = 0; i < 16; i++) imem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) regs[wr_addr] <= wr_data;
            if (prog_we && state == S_IDLE) imem[prog_addr] <= prog_data;
            // Forward a write landing this edge so the read reflects it one cycle later.
            if (wr_en && wr_addr == rd_addr) rd_data <= wr_data;
            else                             rd_data <= regs[rd_addr];
        end
    end

    // wd counts cycles elapsed since the ISSUE cycle; expiry leaves err visible 63 cycles after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            pc              <= '0;
            wd              <= '0;
            err             <= 1'b0;
            seq_done        <= 1'b0;
            au.au_start     <= 1'b0;
            au.au_R         <= '0;
            au.au_S         <= '0;
            au.au_Iimm      <= '0;
            au.au_op_sel    <= '0;
            au.au_mul_y_sel <= '0;
        end else begin
            au.au_start <= 1'b0;
            seq_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        pc    <= '0;
                        err   <= 1'b0;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    au.au_start     <= 1'b1;
                    au.au_R         <= regs[i_ra];
                    au.au_S         <= regs[i_rb];
                    au.au_Iimm      <= {i_sgn, IMM_ONE};
                    au.au_op_sel    <= i_op;
                    au.au_mul_y_sel <= i_ysel;
                    wd              <= 6'd1;
                    state           <= S_WAIT;
                end
                S_WAIT: begin
                    if (au.au_done) begin
                        if (i_last || pc == 4'd15) begin
                            seq_done <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            pc    <= pc + 4'd1;
                            state <= S_ISSUE;
                        end
                    end else if (wd == 6'd62) begin
                        wd    <= 6'd63;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + 6'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_au_sequencer.sv
// Directed bench for au_sequencer with a behavioural arithmetic-unit responder,
// event monitor, and a register-readback scoreboard.
module tb_au_sequencer;
    localparam int W    = 24;
    localparam int FRAC = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_we = 1'b0;
    logic [3:0]    prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic          reg_we = 1'b0;
    logic [2:0]    reg_addr = '0;
    logic [W-1:0]  reg_wdata = '0;
    logic [2:0]    rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          run = 1'b0;
    logic          busy;
    logic          seq_done;
    logic          err;
    logic [1:0]    state_dbg;

    au_sequencer_if #(.W(W)) au_if ();

    au_sequencer #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .run(run), .busy(busy), .seq_done(seq_done), .err(err),
        .state_dbg(state_dbg), .au(au_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [2:0]   addr_q[$];

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- arithmetic unit responder ----------------
    function automatic longint sm_val(input logic [W-1:0] x);
        return x[W-1] ? -longint'(x[W-2:0]) : longint'(x[W-2:0]);
    endfunction

    function automatic logic [W-1:0] sm_pack(input longint v);
        longint m;
        m = (v < 0) ? -v : v;
        return {(v < 0), m[W-2:0]};
    endfunction

    task automatic au_model(input logic [1:0] op, input logic [1:0] ysel,
                            input logic [W-1:0] r, input logic [W-1:0] s, input logic [W-1:0] imm,
                            output logic [W-1:0] res, output int lat);
        longint a, b, y, one;
        one = longint'(1) << FRAC;
        a = sm_val(r);
        b = sm_val(s);
        lat = 2;
        case (op)
            2'd0: res = sm_pack(a + b);
            2'd1: res = sm_pack(a - b);
            2'd2: begin
                if (ysel == 2'd0)      y = b;
                else if (ysel == 2'd1) y = sm_val(imm);
                else begin
                    y = (b == 0) ? 0 : (one * one) / b;
                    lat = 26;
                end
                res = sm_pack((a * y) / one);
            end
            default: begin
                res = sm_pack((b == 0) ? 0 : (a * one) / b);
                lat = 26;
            end
        endcase
    endtask

    int cyc = 0;
    int stub_cnt = 0;
    bit stub_hang = 1'b0;
    logic [W-1:0] stub_res;
    int stub_lat;

    initial begin
        au_if.au_done   = 1'b0;
        au_if.au_busy   = 1'b0;
        au_if.au_result = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            au_if.au_done = 1'b0;
            if (au_if.au_start) begin
                au_model(au_if.au_op_sel, au_if.au_mul_y_sel, au_if.au_R, au_if.au_S,
                         au_if.au_Iimm, stub_res, stub_lat);
                stub_cnt = stub_hang ? 0 : stub_lat;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    au_if.au_done   = 1'b1;
                    au_if.au_result = stub_res;
                end
            end
            au_if.au_busy = (stub_cnt > 0);
        end
    end

    // ---------------- event monitor ----------------
    int n_start, n_seqdone, n_unstable;
    int done_cyc = -100, seq_done_cyc = -100, issue_cyc = -100, err_cyc = -100;
    int first_start_cyc = -100;
    logic err_q = 1'b0;
    logic [W-1:0] prev_R = '0, prev_S = '0, rd_after_done = '0;
    logic [W-1:0] st_R[$];
    logic [W-1:0] st_I[$];
    logic [3:0]   st_ctl[$];

    initial forever begin
        @(negedge clk);
        if (au_if.au_start) begin
            if (n_start == 0) first_start_cyc = cyc;
            n_start++;
            st_R.push_back(au_if.au_R);
            st_I.push_back(au_if.au_Iimm);
            st_ctl.push_back({au_if.au_op_sel, au_if.au_mul_y_sel});
        end
        if (seq_done) begin
            n_seqdone++;
            seq_done_cyc = cyc;
        end
        if (au_if.au_done) done_cyc = cyc;
        if (cyc == done_cyc + 1) rd_after_done = rd_data;
        if (state_dbg == 2'd1) issue_cyc = cyc;
        if (err && !err_q) err_cyc = cyc;
        err_q = err;
        if (state_dbg == 2'd2 && !au_if.au_start && (au_if.au_R !== prev_R || au_if.au_S !== prev_S))
            n_unstable++;
        prev_R = au_if.au_R;
        prev_S = au_if.au_S;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] enc(input logic [1:0] op, input logic [1:0] ysel,
                                        input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                                        input logic sgn, input logic last);
        return {op, ysel, rd, ra, rb, sgn, last, 1'b0};
    endfunction

    task automatic write_reg(input logic [2:0] a, input logic [W-1:0] v);
        @(negedge clk); reg_we = 1'b1; reg_addr = a; reg_wdata = v;
        @(negedge clk); reg_we = 1'b0;
    endtask

    task automatic write_prog(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk); prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk); prog_we = 1'b0;
    endtask

    task automatic clear_mon();
        n_start = 0; n_seqdone = 0; n_unstable = 0;
        st_R.delete(); st_I.delete(); st_ctl.delete();
    endtask

    task automatic run_prog();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        chk("wait_idle_timeout", 32'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_reg(input logic [2:0] a, input logic [W-1:0] v);
        addr_q.push_back(a);
        exp_q.push_back(v);
    endtask

    task automatic drain_regs();
        logic [W-1:0] e;
        logic [2:0]   a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = addr_q.pop_front();
            @(negedge clk); rd_addr = a;
            @(negedge clk);
            chk($sformatf("reg%0d", a), 32'(rd_data), 32'(e));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_mon();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_au_start", 32'(au_if.au_start), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Sixteen un-terminated ADD r0=r0+r0 from the cleared store: stops at pc=15.
        write_reg(3'd0, 24'h000001);
        clear_mon();
        run_prog();
        wait_idle(400);
        chk("wrap_starts", n_start, 16);
        chk("wrap_seqdone", n_seqdone, 1);
        expect_reg(3'd0, 24'h010000);
        drain_regs();

        // ADD 1.5 + 0.25.
        write_reg(3'd0, 24'h006000);
        write_reg(3'd1, 24'h001000);
        write_prog(4'd0, enc(2'd0, 2'd0, 3'd2, 3'd0, 3'd1, 1'b0, 1'b1));
        rd_addr = 3'd2;
        clear_mon();
        run_prog();
        wait_idle(100);
        chk("add_starts", n_start, 1);
        chk("add_seqdone", n_seqdone, 1);
        chk("add_seqdone_lag", seq_done_cyc - done_cyc, 1);
        chk("add_latency", seq_done_cyc - first_start_cyc, 3);
        chk("add_rd_bypass", 32'(rd_after_done), 32'h007000);
        expect_reg(3'd2, 24'h007000);
        expect_reg(3'd0, 24'h006000);
        expect_reg(3'd1, 24'h001000);
        drain_regs();

        // DIV 1.0 / 2.0 with run, reg_we and prog_we thrown at it while busy.
        write_reg(3'd0, 24'h004000);
        write_reg(3'd1, 24'h008000);
        write_prog(4'd0, enc(2'd3, 2'd0, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1));
        clear_mon();
        run_prog();
        repeat (5) @(negedge clk);
        chk("div_busy", 32'(busy), 1);
        run = 1'b1; reg_we = 1'b1; reg_addr = 3'd7; reg_wdata = 24'h123456;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = enc(2'd0, 2'd0, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1);
        @(negedge clk);
        run = 1'b0; reg_we = 1'b0; prog_we = 1'b0;
        wait_idle(200);
        chk("div_starts", n_start, 1);
        chk("div_seqdone", n_seqdone, 1);
        chk("div_operands_stable", n_unstable, 0);
        chk("div_latency", seq_done_cyc - first_start_cyc, 27);
        expect_reg(3'd3, 24'h002000);
        expect_reg(3'd7, 24'h000000);
        drain_regs();
        clear_mon();
        run_prog();
        wait_idle(200);
        chk("div_rerun_latency", seq_done_cyc - first_start_cyc, 27);
        expect_reg(3'd3, 24'h002000);
        drain_regs();

        // Chain: MUL by immediate -1.0, SUB r4-r4, ADD last.
        write_prog(4'd0, enc(2'd2, 2'd1, 3'd4, 3'd0, 3'd0, 1'b1, 1'b0));
        write_prog(4'd1, enc(2'd1, 2'd0, 3'd4, 3'd4, 3'd4, 1'b0, 1'b0));
        write_prog(4'd2, enc(2'd0, 2'd0, 3'd5, 3'd4, 3'd0, 1'b0, 1'b1));
        clear_mon();
        run_prog();
        wait_idle(200);
        chk("chain_starts", n_start, 3);
        chk("chain_seqdone", n_seqdone, 1);
        chk("chain_latency", seq_done_cyc - first_start_cyc, 11);
        if (n_start == 3) begin
            chk("chain_mul_imm", 32'(st_I[0]), 32'h804000);
            chk("chain_mul_ctl", 32'(st_ctl[0]), 32'h9);
            chk("chain_sub_R", 32'(st_R[1]), 32'h804000);
        end
        expect_reg(3'd4, 24'h000000);
        expect_reg(3'd5, 24'h004000);
        drain_regs();

        // Unit that never answers: watchdog.
        write_reg(3'd6, 24'h0AB000);
        write_prog(4'd0, enc(2'd0, 2'd0, 3'd6, 3'd0, 3'd1, 1'b0, 1'b1));
        stub_hang = 1'b1;
        clear_mon();
        run_prog();
        wait_idle(200);
        stub_hang = 1'b0;
        chk("wdog_err", 32'(err), 1);
        chk("wdog_busy", 32'(busy), 0);
        chk("wdog_timing", err_cyc - issue_cyc, 63);
        chk("wdog_seqdone", n_seqdone, 0);
        expect_reg(3'd6, 24'h0AB000);
        drain_regs();

        // Reset in the middle of a DIV, stale done afterwards, then a fresh program.
        write_prog(4'd0, enc(2'd3, 2'd0, 3'd3, 3'd0, 3'd1, 1'b0, 1'b1));
        run_prog();
        chk("rerun_clears_err", 32'(err), 0);
        repeat (8) @(negedge clk);
        chk("mid_div_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_state", 32'(state_dbg), 0);
        chk("mrst_au_start", 32'(au_if.au_start), 0);
        chk("mrst_au_R", 32'(au_if.au_R), 0);
        chk("mrst_au_S", 32'(au_if.au_S), 0);
        chk("mrst_au_Iimm", 32'(au_if.au_Iimm), 0);
        chk("mrst_ctl", 32'({au_if.au_op_sel, au_if.au_mul_y_sel}), 0);
        chk("mrst_seq_done", 32'(seq_done), 0);
        chk("mrst_rd_data", 32'(rd_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (30) @(negedge clk);
        chk("stale_busy", 32'(busy), 0);
        chk("stale_seqdone", n_seqdone, 0);
        chk("stale_err", 32'(err), 0);
        expect_reg(3'd3, 24'h000000);
        expect_reg(3'd0, 24'h000000);
        drain_regs();
        write_reg(3'd0, 24'h006000);
        write_reg(3'd1, 24'h001000);
        write_prog(4'd0, enc(2'd1, 2'd0, 3'd2, 3'd0, 3'd1, 1'b0, 1'b1));
        clear_mon();
        run_prog();
        wait_idle(100);
        chk("post_rst_starts", n_start, 1);
        chk("post_rst_seqdone", n_seqdone, 1);
        expect_reg(3'd2, 24'h005000);
        drain_regs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/au_sequencer.md
AU_SEQUENCER -- requirements
Module: au_sequencer

Interface
REQ-001 SHALL have parameter W, default 24, meaning sign-magnitude word width (matches au).
REQ-002 SHALL have parameter FRAC, default 14, meaning fractional magnitude bits; immediate 1.0 = 1<<FRAC.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port prog_we / prog_addr / prog_data  in  1/4/16  host write of 16-entry instruction store.
REQ-006 SHALL have port reg_we / reg_addr / reg_wdata  in  1/3/W  host write of 8-entry register file.
REQ-007 SHALL have port rd_addr  in  3  and port rd_data  out  W  registered host read, 1-cycle latency.
REQ-008 SHALL have port run  in  1  pulse starting program at pc=0.
REQ-009 SHALL have ports busy  out  1, seq_done  out  1 (1-cycle pulse), err  out  1 (sticky timeout flag).
REQ-010 SHALL have ports au_start  out  1, au_R / au_S / au_Iimm  out  W, au_op_sel  out  2, au_mul_y_sel  out  2  drive au.
REQ-011 SHALL have ports au_result  in  W, au_done  in  1, au_busy  in  1  from au.

Function
REQ-012 SHALL decode instruction bits: [15:14] op (00 ADD, 01 SUB, 10 MUL, 11 DIV), [13:12] mul_y_sel, [11:9] rd, [8:6] ra, [5:3] rb, [2] immediate sign, [1] last, [0] ignored.
REQ-013 SHALL implement states IDLE, ISSUE, WAIT.
REQ-014 IDLE: run=1 -> pc<=0, err<=0, go ISSUE; busy=0 only in IDLE.
REQ-015 ISSUE: au_start=1 for exactly this one cycle; au_R<=reg[ra], au_S<=reg[rb], au_Iimm<={imm sign, 1<<FRAC}, au_op_sel/au_mul_y_sel from instruction; go WAIT.
REQ-016 au_R/au_S/au_Iimm/au_op_sel/au_mul_y_sel SHALL be registered and held stable from ISSUE until the cycle after au_done (au multiply path reads au_R live).
REQ-017 WAIT: on au_done=1, reg[rd]<=au_result same edge; if last=1 or pc=15 -> seq_done pulse next cycle, go IDLE; else pc<=pc+1, go ISSUE.
REQ-018 Per-instruction latency: ADD/SUB/MUL(S or Iimm) done 2 cycles after au_start; DIV/MUL-inv about 26 cycles; sequencer SHALL add 1 cycle between au_done and next au_start.
REQ-019 WAIT SHALL run a 6-bit watchdog cleared at ISSUE; reaching 63 with no au_done -> err<=1, go IDLE, no writeback, no seq_done.
REQ-020 au_done and watchdog expiry in the same cycle: au_done wins, no err.
REQ-021 au_done seen outside WAIT SHALL be ignored.
REQ-022 run while busy SHALL be ignored; prog_we and reg_we while busy SHALL be ignored.
REQ-023 Register writeback in the same instruction where ra or rb = rd: operands already latched, result overwrites rd only.
REQ-024 au_busy is informational; issue SHALL never occur while au_busy=1 (guaranteed by WAIT).
REQ-025 rd_data SHALL return register contents including same-cycle writeback on the following cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, pc=0, au_start=0, busy=0, seq_done=0, err=0, all au_* operand/control outputs 0, rd_data 0, and clear register file and instruction store to 0.
REQ-027 Reset asserted during WAIT SHALL abandon the op; a late au_done after release SHALL be ignored per REQ-021.

Verification
REQ-028 ADD: r0=0x006000 (1.5), r1=0x001000 (0.25), instr ADD rd=2 ra=0 rb=1 last -> au_start pulse, r2=0x007000, seq_done 1 cycle after au_done.
REQ-029 DIV with au instance: r0=0x004000, r1=0x008000, DIV rd=3 last -> r3=0x002000; au_R/au_S stable throughout WAIT.
REQ-030 Three-instruction chain MUL(Iimm, sign=1) r0=0x004000 -> r4=0x804000, then SUB r4-r4 -> 0, then last ADD -> exactly 3 au_start pulses, one seq_done.
REQ-031 AU stub never asserts done -> err=1 exactly 63 cycles after ISSUE, busy=0, no writeback.
REQ-032 rst_n low mid-DIV then run new program -> all outputs zero during reset, new program completes correctly, stale done ignored.
REQ-033 run and reg_we asserted during busy -> no restart, register unchanged.
